// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-serial load/store sequencer between the CPU
// load/store path and an 8-bit memory controller. One request is in flight
// at a time; loads are assembled little-endian and sign/zero extended.
// Optional feature macro: MAU_TIMEOUT_EN. When it is defined, an access
// that sees 16 consecutive stalled cycles is abandoned with rsp_err=1.
module mem_access_unit #(
  parameter int unsigned addressWidth = 32,
  parameter int unsigned dataWidth    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [addressWidth-1:0] req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [addressWidth-1:0] mem_addr,
  output logic [dataWidth-1:0]    mem_wdata,
  input  logic [dataWidth-1:0]    mem_rdata,
  input  logic                    mem_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state_q;
  logic [1:0]              size_q;
  logic                    write_q;
  logic                    signed_q;
  logic [31:0]             wdata_q;   // store bytes not yet presented, lane 0 next
  logic [1:0]              idx_q;
  logic [1:0]              last_q;    // index of the final byte (n-1)
  logic [31:0]             asm_q;

  logic                    mem_read_q;
  logic                    mem_write_q;
  logic [addressWidth-1:0] mem_addr_q;
  logic [dataWidth-1:0]    mem_wdata_q;
  logic                    rsp_valid_q;
  logic [31:0]             rsp_rdata_q;
  logic                    rsp_err_q;

`ifdef MAU_TIMEOUT_EN
  logic [3:0]              stall_cnt_q;
`endif

  logic [31:0]             asm_d;
  logic [31:0]             load_d;
  logic                    misaligned_d;
  logic [1:0]              last_d;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Request decode: alignment check and final byte index for the size.
  always_comb begin
    misaligned_d = ((req_size == 2'b01) && req_addr[0]) ||
                   (req_size[1] && (req_addr[1:0] != 2'b00));
    unique case (req_size)
      2'b00:   last_d = 2'd0;
      2'b01:   last_d = 2'd1;
      default: last_d = 2'd3;
    endcase
  end

  // Assembly including the byte on the bus this cycle, and the extended result
  // so the response can be registered on the same edge as the last transfer.
  always_comb begin
    asm_d = asm_q;
    unique case (idx_q)
      2'd0: asm_d[7:0]   = mem_rdata;
      2'd1: asm_d[15:8]  = mem_rdata;
      2'd2: asm_d[23:16] = mem_rdata;
      2'd3: asm_d[31:24] = mem_rdata;
    endcase
    unique case (size_q)
      2'b00:   load_d = {{24{signed_q & asm_d[7]}}, asm_d[7:0]};
      2'b01:   load_d = {{16{signed_q & asm_d[15]}}, asm_d[15:0]};
      default: load_d = asm_d;
    endcase
    if (write_q) begin
      load_d = '0;
    end
  end

  // Sequencer FSM with registered bus and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      size_q      <= '0;
      write_q     <= 1'b0;
      signed_q    <= 1'b0;
      wdata_q     <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      asm_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef MAU_TIMEOUT_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            size_q   <= req_size;
            write_q  <= req_write;
            signed_q <= req_signed;
            idx_q    <= '0;
            last_q   <= last_d;
            asm_q    <= '0;
`ifdef MAU_TIMEOUT_EN
            stall_cnt_q <= '0;
`endif
            if (misaligned_d) begin
              state_q     <= DONE;
              wdata_q     <= '0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q     <= ACCESS;
              mem_addr_q  <= req_addr;
              mem_wdata_q <= req_wdata[7:0];
              wdata_q     <= req_wdata >> 8;
              mem_read_q  <= ~req_write;
              mem_write_q <= req_write;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            asm_q <= asm_d;
`ifdef MAU_TIMEOUT_EN
            stall_cnt_q <= '0;
`endif
            if (idx_q == last_q) begin
              state_q     <= DONE;
              mem_read_q  <= 1'b0;
              mem_write_q <= 1'b0;
              mem_addr_q  <= '0;
              mem_wdata_q <= '0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= load_d;
            end else begin
              idx_q       <= idx_q + 2'd1;
              mem_addr_q  <= mem_addr_q + addressWidth'(1);
              mem_wdata_q <= wdata_q[7:0];
              wdata_q     <= wdata_q >> 8;
            end
          end
`ifdef MAU_TIMEOUT_EN
          else if (stall_cnt_q == 4'hF) begin
            // 16th consecutive stalled cycle: give up, bytes already stored stay.
            state_q     <= DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            stall_cnt_q <= stall_cnt_q + 4'd1;
          end
`endif
        end
        DONE: begin
          state_q     <= IDLE;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded bench for mem_access_unit: a reference model predicts bus
// transfers, response data and latency; monitors compare independently.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.addressWidth(32), .dataWidth(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Environment memory (what the controller holds) and reference memory (model view).
  logic [7:0] bmem    [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] rd_bmem(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  typedef struct packed {logic [31:0] addr; logic wr; logic [7:0] data;} bus_t;
  typedef struct packed {logic [31:0] rdata; logic err;} rsp_t;
  bus_t bus_q[$];
  rsp_t rsp_q[$];

  int stall_cfg[4] = '{0, 0, 0, 0};

  // Reference model: predicts transfers, response and cycles from acceptance
  // to the response cycle. cut>=0 limits the bytes that will transfer.
  function automatic int model(input logic wr, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input int cut, input bit push_rsp);
    int n;
    int nbytes;
    int cyc;
    bit mis;
    bit tmo;
    logic [31:0] a;
    logic [31:0] val;
    rsp_t r;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    mis = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
    if (mis) begin
      r.rdata = '0;
      r.err = 1'b1;
      if (push_rsp) rsp_q.push_back(r);
      return 1;
    end
    nbytes = n;
    tmo = 1'b0;
`ifdef MAU_TIMEOUT_EN
    for (int k = 0; k < n; k++) begin
      if (stall_cfg[k] >= 16) begin
        nbytes = k;
        tmo = 1'b1;
        break;
      end
    end
`endif
    if (cut >= 0) nbytes = cut;
    val = '0;
    cyc = 1;
    for (int j = 0; j < nbytes; j++) begin
      a = addr + 32'(j);
      bus_q.push_back('{addr: a, wr: wr, data: wd[8*j +: 8]});
      if (wr) ref_mem[a] = wd[8*j +: 8];
      val[8*j +: 8] = rd_ref(a);
      cyc += stall_cfg[j] + 1;
    end
    if (tmo) cyc += 16;
    if (size == 2'b00)      val = {{24{sgn & val[7]}}, val[7:0]};
    else if (size == 2'b01) val = {{16{sgn & val[15]}}, val[15:0]};
    r.err = tmo;
    r.rdata = (tmo || wr) ? 32'd0 : val;
    if (push_rsp) rsp_q.push_back(r);
    return cyc;
  endfunction

  // Memory controller behaviour for one cycle, applied at the negedge.
  task automatic drive_mem(inout int k, inout int st);
    int lim;
    if (mem_read || mem_write) begin
      lim = (k < 4) ? stall_cfg[k] : 0;
      if (st < lim) begin
        mem_ready = 1'b0;
        mem_rdata = 8'($urandom);
        st++;
      end else begin
        mem_ready = 1'b1;
        if (mem_write) bmem[mem_addr] = mem_wdata;
        mem_rdata = rd_bmem(mem_addr);
        k++;
        st = 0;
      end
    end else begin
      mem_ready = 1'($urandom);
      mem_rdata = 8'($urandom);
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd);
    int exp_cyc;
    int cyc;
    int k;
    int st;
    bit seen;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    mem_ready = 1'($urandom);
    exp_cyc = model(wr, size, sgn, addr, wd, -1, 1'b1);
    @(posedge clk);
    k = 0; st = 0; cyc = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'($urandom); req_write = 1'($urandom); req_size = 2'($urandom);
      req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      drive_mem(k, st);
      #1;
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      if (rsp_valid) seen = 1'b1;
    end
    chk("rsp_latency", 32'(cyc), 32'(exp_cyc));
    req_valid = 1'b0;
  endtask

  task automatic reset_mid_store();
    int k;
    int st;
    stall_cfg = '{0, 0, 0, 0};
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h0010_0004; req_wdata = 32'h1122_3344;
    void'(model(1'b1, 2'b10, 1'b0, 32'h0010_0004, 32'h1122_3344, 2, 1'b0));
    @(posedge clk);
    k = 0; st = 0;
    repeat (2) begin
      @(negedge clk);
      req_valid = 1'b0;
      drive_mem(k, st);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mid_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'd0);
    chk("rst_mid_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_bytes_sent", 32'(bus_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Response monitor.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  // Bus monitor: every strobed cycle must match the next predicted transfer.
  initial begin
    bus_t b;
    forever begin
      @(negedge clk);
      #1;
      if (mem_read || mem_write) begin
        if (bus_q.size() == 0) begin
          chk("bus_unexpected_strobe", {30'd0, mem_read, mem_write}, 32'd0);
        end else begin
          b = bus_q[0];
          chk("mem_addr", mem_addr, b.addr);
          chk("mem_write", 32'(mem_write), 32'(b.wr));
          chk("mem_read", 32'(mem_read), 32'(!b.wr));
          chk("mem_wdata", 32'(mem_wdata), 32'(b.data));
          if (mem_ready) void'(bus_q.pop_front());
        end
      end else begin
        chk("idle_mem_addr", mem_addr, 32'd0);
        chk("idle_mem_wdata", 32'(mem_wdata), 32'd0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b1;

    issue(1'b1, 2'b10, 1'b0, 32'h0010_0004, 32'hDEAD_BEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h0010_0004, $urandom);
    issue(1'b0, 2'b00, 1'b1, 32'h0010_0007, $urandom);
    issue(1'b0, 2'b00, 1'b0, 32'h0010_0007, $urandom);
    issue(1'b0, 2'b01, 1'b1, 32'h0010_0006, $urandom);
    issue(1'b0, 2'b01, 1'b0, 32'h0010_0006, $urandom);
    issue(1'b0, 2'b10, 1'b0, 32'h0010_0002, $urandom);
    issue(1'b0, 2'b01, 1'b0, 32'h0010_0001, $urandom);
    issue(1'b1, 2'b11, 1'b0, 32'h0010_0003, $urandom);
    issue(1'b1, 2'b01, 1'b1, 32'h0010_0005, $urandom);

    stall_cfg = '{0, 3, 0, 0};
    issue(1'b0, 2'b10, 1'b0, 32'h0010_0004, $urandom);
    stall_cfg = '{0, 20, 0, 0};
    issue(1'b0, 2'b10, 1'b0, 32'h0010_0004, $urandom);
    stall_cfg = '{0, 0, 20, 0};
    issue(1'b1, 2'b10, 1'b0, 32'h0010_0010, 32'hCAFE_F00D);
    stall_cfg = '{0, 0, 0, 0};
    issue(1'b0, 2'b10, 1'b0, 32'h0010_0010, $urandom);

    reset_mid_store();
    issue(1'b0, 2'b10, 1'b0, 32'h0010_0004, $urandom);

    for (int i = 0; i < 150; i++) begin
      for (int j = 0; j < 4; j++)
        stall_cfg[j] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 0;
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else                           a = 32'h0010_0000 + 32'($urandom_range(0, 63));
      issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("bus_q_left", 32'(bus_q.size()), 32'd0);
    chk("rsp_q_left", 32'(rsp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
